// File: rtl/seq_calculator.sv
// seq_calculator: handshaked add/sub/mul/div/mod on WIDTH-bit unsigned operands.
// Add/sub/mul and the error cases finish at accept time. Div/mod with a non-zero
// divisor run a restoring divider, MSB first, one step per cycle.
module seq_calculator #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         oper,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               err
);
  localparam int unsigned OW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mod_q, mod_d;
  logic [OW-1:0]    out_q, out_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             slow_op;
  logic [OW-1:0]    fast_out;
  logic             fast_err;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign slow_op   = ((oper == OP_DIV) || (oper == OP_MOD)) && (b != '0);
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign err       = err_q;

  // Single-cycle results; the div/mod arms only apply to a zero divisor
  always_comb begin
    fast_out = '0;
    fast_err = 1'b0;
    case (oper)
      OP_ADD: fast_out = OW'(a) + OW'(b);
      OP_SUB: fast_out = OW'(a) - OW'(b);
      OP_MUL: fast_out = OW'(a) * OW'(b);
      OP_DIV: begin
        fast_out = OW'({WIDTH{1'b1}});
        fast_err = 1'b1;
      end
      OP_MOD: begin
        fast_out = OW'(a);
        fast_err = 1'b1;
      end
      default: fast_err = 1'b1;
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]};
    diff  = trial - {1'b0, dvs_q};
    if (diff[WIDTH]) begin
      rem_step = trial[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_step = diff[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = slow_op ? BUSY : DONE;
      BUSY: if (cnt_q == CW'(1)) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_comb begin
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    mod_d       = mod_q;
    out_d       = out_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rem_d = '0;
          quo_d = a;
          dvs_d = b;
          cnt_d = CW'(WIDTH);
          mod_d = (oper == OP_MOD);
          if (!slow_op) begin
            out_d       = fast_out;
            err_d       = fast_err;
            out_valid_d = 1'b1;
          end
        end
      end
      BUSY: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - CW'(1);
        // The final step's combinational result goes straight to the output
        if (cnt_q == CW'(1)) begin
          out_d       = mod_q ? OW'(rem_step) : OW'(quo_step);
          err_d       = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      DONE: if (out_ready) out_valid_d = 1'b0;
      default: out_valid_d = 1'b0;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      mod_q       <= 1'b0;
      out_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      mod_q       <= mod_d;
      out_q       <= out_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_seq_calculator.sv
// Bench for seq_calculator: directed table, backpressure and reset sequences on
// WIDTH=4, then randomized traffic on WIDTH=4 and WIDTH=8 against a reference model.
module tb_seq_calculator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        sel8 = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [2:0]  oper = '0;

  logic        in_ready4, out_valid4, err4;
  logic [7:0]  out4;
  logic        in_ready8, out_valid8, err8;
  logic [15:0] out8;

  logic        obs_in_ready, obs_out_valid, obs_err;
  logic [15:0] obs_out;

  int checks = 0;
  int errors = 0;

  seq_calculator #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a[3:0]), .b(b[3:0]), .oper(oper), .out_valid(out_valid4),
    .out_ready(out_ready), .out(out4), .err(err4)
  );

  seq_calculator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a), .b(b), .oper(oper), .out_valid(out_valid8),
    .out_ready(out_ready), .out(out8), .err(err8)
  );

  assign obs_in_ready  = sel8 ? in_ready8  : in_ready4;
  assign obs_out_valid = sel8 ? out_valid8 : out_valid4;
  assign obs_err       = sel8 ? err8       : err4;
  assign obs_out       = sel8 ? out8       : {8'h00, out4};

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] out;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference model: plain arithmetic on the operation's definition
  task automatic model(input int w, input logic [2:0] op, input logic [31:0] xa,
                       input logic [31:0] xb, output logic [31:0] eo,
                       output logic ee, output int el);
    logic [31:0] mask, om;
    mask = (32'd1 << w) - 32'd1;
    om   = (32'd1 << (2 * w)) - 32'd1;
    xa   = xa & mask;
    xb   = xb & mask;
    ee   = 1'b0;
    el   = 1;
    case (op)
      3'd0: eo = xa + xb;
      3'd1: eo = (xa - xb) & om;
      3'd2: eo = xa * xb;
      3'd3: if (xb == 0) begin eo = mask; ee = 1'b1; end
            else begin eo = xa / xb; el = w + 1; end
      3'd4: if (xb == 0) begin eo = xa; ee = 1'b1; end
            else begin eo = xa % xb; el = w + 1; end
      default: begin eo = 32'd0; ee = 1'b1; end
    endcase
  endtask

  // Issue one op with out_ready high; checks latency, value and err
  task automatic do_op(input logic [2:0] op, input logic [7:0] aa, input logic [7:0] bb,
                       input logic [15:0] eo, input logic ee, input int el, input string nm);
    int n;
    @(negedge clk);
    check({nm, "_in_ready"}, 32'(obs_in_ready), 32'd1);
    in_valid = 1'b1; a = aa; b = bb; oper = op; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!obs_out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, 32'(n), 32'(el));
    check({nm, "_out"}, 32'(obs_out), 32'(eo));
    check({nm, "_err"}, 32'(obs_err), 32'(ee));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(obs_out_valid), 32'd0);
    check("reset_out", 32'(obs_out), 32'd0);
    check("reset_err", 32'(obs_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(obs_in_ready), 32'd1);
  endtask

  task automatic rand_run(input bit w8, input int ncyc);
    logic [31:0] mask, eo;
    logic        ee;
    int          el, n, w, r;
    bit          pending, acc, hs;
    w = w8 ? 8 : 4;
    mask = w8 ? 32'hFF : 32'hF;
    sel8 = w8;
    do_reset();
    pending = 1'b0; acc = 1'b0; n = 0; eo = '0; ee = 1'b0; el = 1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (acc) in_valid = 1'b0;
      if (pending) begin
        n++;
        check("rand_in_ready_busy", 32'(obs_in_ready), 32'd0);
        if (n < el) check("rand_early_valid", 32'(obs_out_valid), 32'd0);
        else        check("rand_valid_timing", 32'(obs_out_valid), 32'd1);
        if (obs_out_valid) begin
          check("rand_out", 32'(obs_out), eo);
          check("rand_err", 32'(obs_err), 32'(ee));
        end
      end else begin
        check("rand_in_ready_idle", 32'(obs_in_ready), 32'd1);
        check("rand_spurious_valid", 32'(obs_out_valid), 32'd0);
      end
      if (!in_valid && $urandom_range(0, 2) != 0) begin
        r = int'($urandom_range(0, 15));
        if (r < 3)       oper = 3'd0;
        else if (r < 6)  oper = 3'd1;
        else if (r < 9)  oper = 3'd2;
        else if (r < 12) oper = 3'd3;
        else if (r < 14) oper = 3'd4;
        else             oper = 3'($urandom_range(5, 7));
        a = 8'($urandom & mask);
        b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom & mask);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      acc = in_valid && obs_in_ready;
      hs  = obs_out_valid && out_ready;
      if (hs) pending = 1'b0;
      if (acc) begin
        model(w, oper, 32'(a), 32'(b), eo, ee, el);
        pending = 1'b1;
        n = 0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    vecs[0]  = '{3'd0, 8'h9, 8'h7, 16'h10, 1'b0, 1};
    vecs[1]  = '{3'd1, 8'h3, 8'h5, 16'hFE, 1'b0, 1};
    vecs[2]  = '{3'd2, 8'hF, 8'hF, 16'hE1, 1'b0, 1};
    vecs[3]  = '{3'd3, 8'hD, 8'h4, 16'h03, 1'b0, 5};
    vecs[4]  = '{3'd4, 8'hD, 8'h4, 16'h01, 1'b0, 5};
    vecs[5]  = '{3'd3, 8'hF, 8'h1, 16'h0F, 1'b0, 5};
    vecs[6]  = '{3'd3, 8'h2, 8'h7, 16'h00, 1'b0, 5};
    vecs[7]  = '{3'd3, 8'h9, 8'h0, 16'h0F, 1'b1, 1};
    vecs[8]  = '{3'd4, 8'h9, 8'h0, 16'h09, 1'b1, 1};
    vecs[9]  = '{3'd6, 8'h5, 8'h3, 16'h00, 1'b1, 1};
    vecs[10] = '{3'd1, 8'h0, 8'hF, 16'hF1, 1'b0, 1};
    vecs[11] = '{3'd4, 8'hF, 8'hF, 16'h00, 1'b0, 5};

    sel8 = 1'b0;
    do_reset();

    for (int i = 0; i < 12; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].out, vecs[i].err, vecs[i].lat,
            $sformatf("vec%0d", i));

    // Backpressure: result held while a competing add waits
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'hD; b = 8'h4; oper = 3'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!obs_out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("bp_latency", 32'(n), 32'd5);
    in_valid = 1'b1; a = 8'h1; b = 8'h1; oper = 3'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(obs_out_valid), 32'd1);
      check("bp_out", 32'(obs_out), 32'h03);
      check("bp_in_ready", 32'(obs_in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 32'(obs_in_ready), 32'd1);
    check("bp_release_out_valid", 32'(obs_out_valid), 32'd0);
    check("bp_release_out_kept", 32'(obs_out), 32'h03);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_add_valid", 32'(obs_out_valid), 32'd1);
    check("bp_add_out", 32'(obs_out), 32'h02);
    check("bp_add_err", 32'(obs_err), 32'd0);

    // Reset during the second BUSY cycle of a divide
    @(negedge clk);
    check("rst_mid_in_ready", 32'(obs_in_ready), 32'd1);
    in_valid = 1'b1; a = 8'hD; b = 8'h4; oper = 3'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_out_valid", 32'(obs_out_valid), 32'd0);
    check("rst_mid_out", 32'(obs_out), 32'd0);
    check("rst_mid_err", 32'(obs_err), 32'd0);
    check("rst_mid_in_ready_after", 32'(obs_in_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_mid_no_stale", 32'(obs_out_valid), 32'd0);
    end
    do_op(3'd0, 8'h2, 8'h3, 16'h05, 1'b0, 1, "post_rst_add");

    rand_run(1'b0, 1500);
    rand_run(1'b1, 1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
